// File: rtl/cr_huf_comp_is_short_hist.sv
// Consumer of the short-symbol compaction FIFO: accumulates per-symbol repeat
// counts into a frequency table and streams the table out on end-of-block.
module cr_huf_comp_is_short_hist #(
  parameter int NUM_SYM = 576,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       sc_is_short_vld,
  input  logic [9:0]       sc_is_short_short0,
  input  logic [9:0]       sc_is_short_short1,
  input  logic [9:0]       sc_is_short_short2,
  input  logic [9:0]       sc_is_short_short3,
  input  logic [2:0]       sc_is_short_cnt0,
  input  logic [2:0]       sc_is_short_cnt1,
  input  logic [2:0]       sc_is_short_cnt2,
  input  logic [2:0]       sc_is_short_cnt3,
  input  logic [3:0]       sc_is_short_seq_id,
  input  logic [1:0]       sc_is_short_eob,
  output logic             is_sc_short_rd,
  output logic             hist_vld,
  input  logic             hist_rdy,
  output logic [9:0]       hist_sym,
  output logic [CNT_W-1:0] hist_cnt,
  output logic             hist_last,
  output logic [3:0]       hist_seq_id,
  output logic             hist_sat,
  output logic             oor_err,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Histogram handshake: a word transfers on any cycle where hist_vld and
  // hist_rdy are both high; while hist_rdy is low every hist_* output holds.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ACCUM = 2'd1,
    DUMP  = 2'd2
  } state_t;

  localparam logic [10:0] SYM_LIM  = 11'(NUM_SYM);
  localparam logic [9:0]  LAST_IDX = 10'(NUM_SYM - 1);

  state_t           state;
  logic [9:0]       sym_q [4];
  logic [2:0]       cnt_q [4];
  logic [3:0]       seq_q;
  logic             eob_q;
  logic [1:0]       slot;
  logic [9:0]       dump_idx;
  logic [CNT_W-1:0] freq_tab [NUM_SYM];

  logic [9:0]       cur_sym;
  logic [2:0]       cur_cnt;
  logic [2:0]       nxt_cnt;
  logic             cur_in_range;
  logic [9:0]       acc_addr;
  logic [CNT_W:0]   acc_sum;
  logic [CNT_W-1:0] acc_val;
  logic             do_acc;
  logic             slot_last;
  logic             fetch_go;
  logic             hs;
  logic             dump_end;

  always_comb begin
    cur_sym      = sym_q[slot];
    cur_cnt      = cnt_q[slot];
    nxt_cnt      = (slot == 2'd3) ? 3'd0 : cnt_q[slot + 2'd1];
    cur_in_range = ({1'b0, cur_sym} < SYM_LIM);
    acc_addr     = cur_in_range ? cur_sym : 10'd0;
    // One extra bit on the adder: its carry-out is the saturation flag.
    acc_sum      = {1'b0, freq_tab[acc_addr]} + (CNT_W + 1)'(cur_cnt);
    acc_val      = acc_sum[CNT_W] ? {CNT_W{1'b1}} : acc_sum[CNT_W-1:0];
    do_acc       = (state == ACCUM) && (cur_cnt != 3'd0) && cur_in_range;
    slot_last    = (slot == 2'd3) || (nxt_cnt == 3'd0) || (cur_cnt == 3'd0);
    fetch_go     = !rst && (state == FETCH) && (sc_is_short_vld == 4'b1111);
    hs           = (state == DUMP) && hist_rdy;
    dump_end     = hs && (dump_idx == LAST_IDX);
  end

  assign is_sc_short_rd = fetch_go;
  assign hist_vld       = (state == DUMP);
  assign hist_sym       = dump_idx;
  assign hist_cnt       = (state == DUMP) ? freq_tab[dump_idx] : '0;
  assign hist_last      = (state == DUMP) && (dump_idx == LAST_IDX);
  assign busy           = (state != FETCH);
  assign dbg_state      = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      slot        <= 2'd0;
      dump_idx    <= 10'd0;
      seq_q       <= 4'd0;
      eob_q       <= 1'b0;
      hist_seq_id <= 4'd0;
      hist_sat    <= 1'b0;
      oor_err     <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        sym_q[i] <= 10'd0;
        cnt_q[i] <= 3'd0;
      end
    end else begin
      case (state)
        FETCH: begin
          if (fetch_go) begin
            sym_q[0] <= sc_is_short_short0;
            sym_q[1] <= sc_is_short_short1;
            sym_q[2] <= sc_is_short_short2;
            sym_q[3] <= sc_is_short_short3;
            cnt_q[0] <= sc_is_short_cnt0;
            cnt_q[1] <= sc_is_short_cnt1;
            cnt_q[2] <= sc_is_short_cnt2;
            cnt_q[3] <= sc_is_short_cnt3;
            seq_q    <= sc_is_short_seq_id;
            eob_q    <= (sc_is_short_eob != 2'd0);
            slot     <= 2'd0;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          if ((cur_cnt != 3'd0) && !cur_in_range)
            oor_err <= 1'b1;
          if (do_acc && acc_sum[CNT_W])
            hist_sat <= 1'b1;
          if (slot_last) begin
            if (eob_q) begin
              state       <= DUMP;
              dump_idx    <= 10'd0;
              hist_seq_id <= seq_q;
            end else begin
              state <= FETCH;
            end
          end else begin
            slot <= slot + 2'd1;
          end
        end
        DUMP: begin
          if (dump_end) begin
            state    <= FETCH;
            dump_idx <= 10'd0;
            hist_sat <= 1'b0;
          end else if (hs) begin
            dump_idx <= dump_idx + 10'd1;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  // Accumulate and dump never overlap, so one write port serves both.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SYM; i++)
        freq_tab[i] <= '0;
    end else if (do_acc) begin
      freq_tab[acc_addr] <= acc_val;
    end else if (hs) begin
      freq_tab[dump_idx] <= '0;
    end
  end

endmodule

// File: tb/tb_cr_huf_comp_is_short_hist.sv
// Directed bench for cr_huf_comp_is_short_hist with a small FIFO model and a
// histogram monitor; counters are 4 bits wide so saturation is reachable.
module tb_cr_huf_comp_is_short_hist;

  localparam int NUM_SYM = 576;
  localparam int CNT_W   = 4;

  typedef struct packed {
    logic [3:0][9:0] s;
    logic [3:0][2:0] c;
    logic [3:0]      seq;
    logic [1:0]      eob;
  } entry_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       sc_is_short_vld = '0;
  logic [9:0]       sc_is_short_short0 = '0, sc_is_short_short1 = '0;
  logic [9:0]       sc_is_short_short2 = '0, sc_is_short_short3 = '0;
  logic [2:0]       sc_is_short_cnt0 = '0, sc_is_short_cnt1 = '0;
  logic [2:0]       sc_is_short_cnt2 = '0, sc_is_short_cnt3 = '0;
  logic [3:0]       sc_is_short_seq_id = '0;
  logic [1:0]       sc_is_short_eob = '0;
  logic             is_sc_short_rd;
  logic             hist_vld;
  logic             hist_rdy = 1'b1;
  logic [9:0]       hist_sym;
  logic [CNT_W-1:0] hist_cnt;
  logic             hist_last;
  logic [3:0]       hist_seq_id;
  logic             hist_sat;
  logic             oor_err;
  logic             busy;
  logic [1:0]       dbg_state;

  cr_huf_comp_is_short_hist #(.NUM_SYM(NUM_SYM), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .sc_is_short_vld(sc_is_short_vld),
    .sc_is_short_short0(sc_is_short_short0), .sc_is_short_short1(sc_is_short_short1),
    .sc_is_short_short2(sc_is_short_short2), .sc_is_short_short3(sc_is_short_short3),
    .sc_is_short_cnt0(sc_is_short_cnt0), .sc_is_short_cnt1(sc_is_short_cnt1),
    .sc_is_short_cnt2(sc_is_short_cnt2), .sc_is_short_cnt3(sc_is_short_cnt3),
    .sc_is_short_seq_id(sc_is_short_seq_id), .sc_is_short_eob(sc_is_short_eob),
    .is_sc_short_rd(is_sc_short_rd),
    .hist_vld(hist_vld), .hist_rdy(hist_rdy), .hist_sym(hist_sym), .hist_cnt(hist_cnt),
    .hist_last(hist_last), .hist_seq_id(hist_seq_id), .hist_sat(hist_sat),
    .oor_err(oor_err), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_errors = 0;
  entry_t     fifo_q[$];
  logic [3:0] exp_q[$];
  int         exp_tab [NUM_SYM];
  int         got_cnt [NUM_SYM];
  int         hs_cnt = 0;
  int         last_seen = 0;
  int         last_sym = 0;
  int         last_sat = 0;
  int         rd_count = 0;
  bit         rdy_rand = 1'b0;
  bit         stall_prev = 1'b0;
  logic [9:0]       p_sym;
  logic [CNT_W-1:0] p_cnt;
  logic             p_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- FIFO model (show-ahead) ----------------
  initial begin
    bit pend;
    forever begin
      @(negedge clk);
      pend = is_sc_short_rd;
      if (pend) begin
        rd_count++;
        check("rd_with_vld", 32'(sc_is_short_vld), 32'hF);
      end
      @(posedge clk);
      #1;
      if (pend && fifo_q.size() > 0) void'(fifo_q.pop_front());
      if (fifo_q.size() > 0) begin
        sc_is_short_vld    = 4'b1111;
        sc_is_short_short0 = fifo_q[0].s[0];
        sc_is_short_short1 = fifo_q[0].s[1];
        sc_is_short_short2 = fifo_q[0].s[2];
        sc_is_short_short3 = fifo_q[0].s[3];
        sc_is_short_cnt0   = fifo_q[0].c[0];
        sc_is_short_cnt1   = fifo_q[0].c[1];
        sc_is_short_cnt2   = fifo_q[0].c[2];
        sc_is_short_cnt3   = fifo_q[0].c[3];
        sc_is_short_seq_id = fifo_q[0].seq;
        sc_is_short_eob    = fifo_q[0].eob;
      end else begin
        sc_is_short_vld    = 4'b0000;
        sc_is_short_short0 = '0; sc_is_short_short1 = '0;
        sc_is_short_short2 = '0; sc_is_short_short3 = '0;
        sc_is_short_cnt0   = '0; sc_is_short_cnt1   = '0;
        sc_is_short_cnt2   = '0; sc_is_short_cnt3   = '0;
        sc_is_short_seq_id = '0; sc_is_short_eob    = '0;
      end
    end
  end

  // ---------------- downstream ready ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      hist_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- histogram monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (stall_prev) begin
        check("stall_vld", 32'(hist_vld), 32'd1);
        check("stall_sym", 32'(hist_sym), 32'(p_sym));
        check("stall_cnt", 32'(hist_cnt), 32'(p_cnt));
        check("stall_last", 32'(hist_last), 32'(p_last));
      end
      stall_prev = hist_vld && !hist_rdy && !rst;
      p_sym  = hist_sym;
      p_cnt  = hist_cnt;
      p_last = hist_last;
      if (hist_vld && hist_rdy) begin
        check("sym_order", 32'(hist_sym), 32'(hs_cnt));
        if (int'(hist_sym) < NUM_SYM) got_cnt[hist_sym] = int'(hist_cnt);
        if (hist_last) begin
          last_seen++;
          last_sym = int'(hist_sym);
          last_sat = int'(hist_sat);
          if (exp_q.size() > 0) check("last_seq_id", 32'(hist_seq_id), 32'(exp_q.pop_front()));
          else check("last_unexpected", 32'(hist_seq_id), 32'hFFFF);
        end
        hs_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input int s0, input int s1, input int s2, input int s3,
                      input int c0, input int c1, input int c2, input int c3,
                      input int seq, input int eob);
    entry_t e;
    e.s[0] = 10'(s0); e.s[1] = 10'(s1); e.s[2] = 10'(s2); e.s[3] = 10'(s3);
    e.c[0] = 3'(c0);  e.c[1] = 3'(c1);  e.c[2] = 3'(c2);  e.c[3] = 3'(c3);
    e.seq  = 4'(seq); e.eob  = 2'(eob);
    fifo_q.push_back(e);
    if (eob != 0) exp_q.push_back(4'(seq));
  endtask

  task automatic clear_capture();
    hs_cnt    = 0;
    last_seen = 0;
    last_sym  = 0;
    last_sat  = 0;
    for (int i = 0; i < NUM_SYM; i++) begin
      got_cnt[i] = -1;
      exp_tab[i] = 0;
    end
  endtask

  task automatic wait_rd(input string tag);
    bit seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      if (is_sc_short_rd) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  task automatic wait_dump(input string tag);
    bit done = 1'b0;
    for (int n = 0; n < 5000 && !done; n++) begin
      @(negedge clk);
      if (hs_cnt >= NUM_SYM && !hist_vld) done = 1'b1;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic check_dump(input string tag, input int exp_sat);
    for (int i = 0; i < NUM_SYM; i++)
      check({tag, "_word"}, 32'(got_cnt[i]), 32'(exp_tab[i]));
    check({tag, "_handshakes"}, 32'(hs_cnt), 32'(NUM_SYM));
    check({tag, "_last_count"}, 32'(last_seen), 32'd1);
    check({tag, "_last_sym"}, 32'(last_sym), 32'(NUM_SYM - 1));
    check({tag, "_sat"}, 32'(last_sat), 32'(exp_sat));
    clear_capture();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    clear_capture();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_hist_vld", 32'(hist_vld), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd", 32'(is_sc_short_rd), 32'd0);
    check("rst_oor", 32'(oor_err), 32'd0);
    check("rst_sat", 32'(hist_sat), 32'd0);
    check("rst_seq", 32'(hist_seq_id), 32'd0);

    // Single entry, then latency from pop to first histogram word.
    rd_count = 0;
    push(5, 9, 0, 0, 3, 1, 0, 0, 7, 1);
    wait_rd("t1_rd_seen");
    @(negedge clk);
    check("t1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("t1_not_yet_dump", 32'(hist_vld), 32'd0);
    @(negedge clk);
    check("t1_dump_start", 32'(hist_vld), 32'd1);
    check("t1_first_sym", 32'(hist_sym), 32'd0);
    wait_dump("t1_dump_done");
    check("t1_rd_pulses", 32'(rd_count), 32'd1);
    exp_tab[5] = 3;
    exp_tab[9] = 1;
    check_dump("t1", 0);

    // Two blocks back to back; 4+4+4 = 12 per block, no carry-over.
    push(12, 0, 0, 0, 4, 0, 0, 0, 1, 0);
    push(12, 0, 0, 0, 4, 0, 0, 0, 1, 0);
    push(12, 0, 0, 0, 4, 0, 0, 0, 1, 1);
    push(12, 0, 0, 0, 4, 0, 0, 0, 2, 0);
    push(12, 0, 0, 0, 4, 0, 0, 0, 2, 0);
    push(12, 0, 0, 0, 4, 0, 0, 0, 2, 2);
    wait_dump("t2a_dump_done");
    exp_tab[12] = 12;
    check_dump("t2a", 0);
    wait_dump("t2b_dump_done");
    exp_tab[12] = 12;
    check_dump("t2b", 0);

    // Saturation: 5 x 4 = 20 clamps to 15; next block starts clean.
    for (int k = 0; k < 5; k++) push(3, 0, 0, 0, 4, 0, 0, 0, 3, (k == 4) ? 1 : 0);
    wait_dump("t3_dump_done");
    exp_tab[3] = 15;
    check_dump("t3", 1);
    push(3, 0, 0, 0, 1, 0, 0, 0, 4, 1);
    wait_dump("t3b_dump_done");
    exp_tab[3] = 1;
    check_dump("t3b", 0);

    // Backpressure with a full four-slot entry.
    rdy_rand = 1'b1;
    push(100, 101, 102, 103, 1, 2, 3, 4, 5, 1);
    wait_dump("t4_dump_done");
    rdy_rand = 1'b0;
    exp_tab[100] = 1; exp_tab[101] = 2; exp_tab[102] = 3; exp_tab[103] = 4;
    check_dump("t4", 0);

    // Out-of-range symbol is dropped and flagged.
    check("t5_oor_before", 32'(oor_err), 32'd0);
    push(600, 20, 0, 0, 2, 1, 0, 0, 6, 1);
    wait_dump("t5_dump_done");
    check("t5_oor_sticky", 32'(oor_err), 32'd1);
    exp_tab[20] = 1;
    check_dump("t5", 0);

    // Empty entry: two cycles from pop to dump, all-zero table.
    push(0, 0, 0, 0, 0, 0, 0, 0, 8, 1);
    wait_rd("t6_rd_seen");
    @(negedge clk);
    check("t6_not_yet_dump", 32'(hist_vld), 32'd0);
    @(negedge clk);
    check("t6_dump_start", 32'(hist_vld), 32'd1);
    wait_dump("t6_dump_done");
    check_dump("t6", 0);

    // Reset mid-dump, before word 200 is read out.
    fifo_q.push_back('{s: {10'd0, 10'd0, 10'd0, 10'd200}, c: {3'd0, 3'd0, 3'd0, 3'd2},
                       seq: 4'd9, eob: 2'd1});
    begin
      bit hit = 1'b0;
      for (int n = 0; n < 1000 && !hit; n++) begin
        @(negedge clk);
        if (hs_cnt >= 100) hit = 1'b1;
      end
      check("t7_reached_100", 32'(hit), 32'd1);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t7_hist_vld", 32'(hist_vld), 32'd0);
    check("t7_hist_sym", 32'(hist_sym), 32'd0);
    check("t7_hist_cnt", 32'(hist_cnt), 32'd0);
    check("t7_hist_last", 32'(hist_last), 32'd0);
    check("t7_hist_seq", 32'(hist_seq_id), 32'd0);
    check("t7_busy", 32'(busy), 32'd0);
    check("t7_oor", 32'(oor_err), 32'd0);
    check("t7_rd", 32'(is_sc_short_rd), 32'd0);
    clear_capture();
    push(0, 0, 0, 0, 0, 0, 0, 0, 10, 1);
    wait_dump("t7_dump_done");
    check_dump("t7", 0);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
